// File: rtl/gpio_input_irq.sv
// gpio_input_irq: memory-mapped GPIO input block with interrupt.
// Pins pass through a 2-flop synchronizer and then a per-bit debouncer.
// Edges of the debounced level are latched into per-bit pending flags,
// gated by the rise/fall enables. irq is high while any pending flag is set.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   read       - bus read strobe (one-cycle read latency)
//   write      - bus write strobe
//   address    - byte address, only [3:2] decoded
//                (0 LEVEL ro, 1 RISE_EN rw, 2 FALL_EN rw, 3 PENDING w1c)
//   write_data - bus write data
//   read_data  - registered bus read data
//   gpio_in    - asynchronous external pins
//   irq        - interrupt, OR of the pending register
module gpio_input_irq #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_LEVEL   = 2'd0;
    localparam logic [1:0] REG_RISE_EN = 2'd1;
    localparam logic [1:0] REG_FALL_EN = 2'd2;
    localparam logic [1:0] REG_PENDING = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [31:0]      read_data_q, read_data_d;

    logic [1:0]       sel_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] clr_c;
    logic [31:0]      rd_mux_c;

    // Address and data bits outside the decoded range are intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{address[31:4], address[1:0], write_data};

    assign sel_c   = address[3:2];
    assign wdata_c = write_data[WIDTH-1:0];

    // Per-bit debounce; a stable-level update also raises the edge event,
    // qualified by the enables as they were before this edge.
    always_comb begin
        stable_d = stable_q;
        set_c    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                set_c[i]    = sync2_q[i] ? rise_en_q[i] : fall_en_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Bus register updates; set beats clear on the same bit.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_c     = '0;
        if (write) begin
            case (sel_c)
                REG_RISE_EN: rise_en_d = wdata_c;
                REG_FALL_EN: fall_en_d = wdata_c;
                REG_PENDING: clr_c     = wdata_c;
                default:     ;
            endcase
        end
        pend_d = (pend_q & ~clr_c) | set_c;
    end

    // Read mux samples pre-write register values.
    always_comb begin
        rd_mux_c = '0;
        case (sel_c)
            REG_LEVEL:   rd_mux_c = 32'(stable_q);
            REG_RISE_EN: rd_mux_c = 32'(rise_en_q);
            REG_FALL_EN: rd_mux_c = 32'(fall_en_q);
            REG_PENDING: rd_mux_c = 32'(pend_q);
            default:     rd_mux_c = '0;
        endcase
        read_data_d = read ? rd_mux_c : read_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            cnt_q       <= '{default: '0};
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pend_q      <= '0;
            read_data_q <= '0;
        end else begin
            sync1_q     <= gpio_in;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            pend_q      <= pend_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;
    // Straight OR of the pending flops; no path from the bus inputs.
    assign irq       = |pend_q;

endmodule
